// File: rtl/qsgmii_fifo_pkg.sv
// Shared types and helpers for the QSGMII FIFO read arbiter.
// Holds the arbiter state encoding and the round-robin channel picker.
package qsgmii_fifo_pkg;

  localparam int MAX_CH = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  // First set bit of mask at or after last+1, wrapping modulo numCh; returns last when mask is empty.
  function automatic logic [2:0] rr_next(input logic [MAX_CH-1:0] mask,
                                         input logic [2:0]        last,
                                         input int                numCh);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= MAX_CH; k++) begin
      idx = (int'(last) + k) % numCh;
      if ((k <= numCh) && !found && mask[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/qsgmii_fifo_rd_arb_skid_buf2.sv
// Two-entry output FIFO of the read arbiter: the head and tail are both flops,
// so the head drives the output port directly.
module qsgmii_skid_buf2 #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_pushData,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_headData,
  output logic [1:0]       o_occ
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_occ;
  logic             w_pop;

  assign w_pop = i_pop && (r_occ != 2'd0);

  // The upstream credit check keeps a push from ever landing on a full buffer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= 2'd0;
    end else begin
      case ({i_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_head <= i_pushData;
          else               r_tail <= i_pushData;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_head <= i_pushData;
          end else begin
            r_head <= r_tail;
            r_tail <= i_pushData;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_valid    = (r_occ != 2'd0);
  assign o_headData = r_head;
  assign o_occ      = r_occ;

endmodule

// File: rtl/qsgmii_fifo_rd_arb.sv
// Round-robin burst scheduler draining NUM_CH async-FIFO read ports into one
// channel-tagged ready/valid stream, with a two-entry credit-protected output buffer.
module qsgmii_fifo_rd_arb
  import qsgmii_fifo_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 2,
  parameter int BURST_LEN  = 8,
  parameter int CH_W       = $clog2(NUM_CH)
) (
  input  logic                         rd_clk,
  input  logic                         rd_rst_n,
  input  logic [NUM_CH-1:0]            ch_en,
  input  logic [NUM_CH-1:0]            fifo_empty,
  input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_rd_data,
  output logic [NUM_CH-1:0]            fifo_rd_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]              out_ch,
  output logic                         busy
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam int BUF_W = DATA_WIDTH + CH_W;

  arb_state_t             r_state, w_stateNext;
  logic [CH_W-1:0]        r_gnt, w_gntNext;
  logic [CH_W-1:0]        r_lastGnt, w_lastGntNext;
  logic [CNT_W-1:0]       r_burstCnt, w_burstCntNext;
  logic                   r_inflight;
  logic [CH_W-1:0]        r_inflightCh;

  logic [NUM_CH-1:0]      w_eligible;
  logic [MAX_CH-1:0]      w_rrMask;
  logic [2:0]             w_rrPick;
  logic                   w_rdIssue;
  logic                   w_creditOk;
  logic                   w_pop;
  logic [1:0]             w_occ;
  logic                   w_headValid;
  logic [BUF_W-1:0]       w_headData;
  logic [DATA_WIDTH-1:0]  w_capData;
  logic [BUF_W-1:0]       w_capWord;

  assign w_eligible = ch_en & ~fifo_empty;
  assign w_rrMask   = MAX_CH'(w_eligible);
  assign w_rrPick   = rr_next(w_rrMask, 3'(r_lastGnt), NUM_CH);

  // A pop in this cycle frees the slot a new read needs; that pop is the only out_ready-dependent term.
  assign w_pop      = w_headValid && out_ready;
  assign w_creditOk = ({1'b0, w_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});

  always_comb begin
    w_stateNext    = r_state;
    w_gntNext      = r_gnt;
    w_lastGntNext  = r_lastGnt;
    w_burstCntNext = r_burstCnt;
    w_rdIssue      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_eligible) begin
          w_gntNext      = CH_W'(w_rrPick);
          w_burstCntNext = '0;
          w_stateNext    = ST_BURST;
        end
      end
      ST_BURST: begin
        if (!fifo_empty[r_gnt] && ch_en[r_gnt]) begin
          if (w_creditOk) begin
            w_rdIssue      = 1'b1;
            w_burstCntNext = r_burstCnt + CNT_W'(1);
            if (r_burstCnt == CNT_W'(BURST_LEN - 1)) begin
              w_stateNext   = ST_IDLE;
              w_lastGntNext = r_gnt;
            end
          end
        end else begin
          w_stateNext   = ST_IDLE;
          w_lastGntNext = r_gnt;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_state      <= ST_IDLE;
      r_gnt        <= '0;
      r_lastGnt    <= CH_W'(NUM_CH - 1);
      r_burstCnt   <= '0;
      r_inflight   <= 1'b0;
      r_inflightCh <= '0;
    end else begin
      r_state      <= w_stateNext;
      r_gnt        <= w_gntNext;
      r_lastGnt    <= w_lastGntNext;
      r_burstCnt   <= w_burstCntNext;
      r_inflight   <= w_rdIssue;
      r_inflightCh <= r_gnt;
    end
  end

  always_comb begin
    fifo_rd_en = '0;
    if (w_rdIssue) fifo_rd_en = NUM_CH'(1) << r_gnt;
  end

  // Read data appears one cycle after rd_en; pick it from the channel the read was issued to.
  always_comb begin
    w_capData = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_inflightCh == CH_W'(i)) w_capData = fifo_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_capWord = {r_inflightCh, w_capData};

  qsgmii_skid_buf2 #(
    .WIDTH(BUF_W)
  ) u_outBuf (
    .i_clk      (rd_clk),
    .i_rst_n    (rd_rst_n),
    .i_push     (r_inflight),
    .i_pushData (w_capWord),
    .i_pop      (w_pop),
    .o_valid    (w_headValid),
    .o_headData (w_headData),
    .o_occ      (w_occ)
  );

  assign out_valid = w_headValid;
  assign out_data  = w_headData[DATA_WIDTH-1:0];
  assign out_ch    = w_headData[DATA_WIDTH +: CH_W];
  assign busy      = (r_state == ST_BURST) || (w_occ != 2'd0);

endmodule

// File: tb/tb_qsgmii_fifo_rd_arb.sv
// Scoreboard bench for qsgmii_fifo_rd_arb: behavioural FIFOs feed the DUT and a
// negedge monitor checks every accepted word against per-channel expected queues.
module tb_qsgmii_fifo_rd_arb;

  localparam int NUM_CH = 4;
  localparam int DW     = 2;
  localparam int BURST  = 8;
  localparam int CW     = 2;
  localparam int DEPTH  = 16;

  logic                 rd_clk;
  logic                 rd_rst_n;
  logic [NUM_CH-1:0]    ch_en;
  logic [NUM_CH-1:0]    fifo_empty;
  logic [NUM_CH*DW-1:0] fifo_rd_data;
  logic [NUM_CH-1:0]    fifo_rd_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_data;
  logic [CW-1:0]        out_ch;
  logic                 busy;

  int testsRun  = 0;
  int failCount = 0;

  logic [DW-1:0]     fifoQ [NUM_CH][$];
  logic [DW-1:0]     expQ  [NUM_CH][$];
  logic [DW-1:0]     rdData [NUM_CH];
  logic [NUM_CH-1:0] fifoEmptyR = '1;

  int rdCount [NUM_CH];
  int readLog [$];
  bit logging       = 1'b0;
  int cycleCnt      = 0;
  int firstRdCycle  = -1;
  int firstOutCycle = -1;
  int outstanding   = 0;
  int popCount      = 0;
  int pushCount     = 0;

  qsgmii_fifo_rd_arb #(
    .NUM_CH     (NUM_CH),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BURST),
    .CH_W       (CW)
  ) dut (
    .rd_clk       (rd_clk),
    .rd_rst_n     (rd_rst_n),
    .ch_en        (ch_en),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_ch       (out_ch),
    .busy         (busy)
  );

  initial begin
    rd_clk = 1'b0;
    forever #5 rd_clk = ~rd_clk;
  end

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      rdData[i]  = '0;
      rdCount[i] = 0;
    end
  end

  function automatic void checkOutput(string name, int act, int req);
    testsRun++;
    if (act != req) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  // Behavioural async-FIFO read ports: registered empty flag, data one cycle after rd_en.
  always @(posedge rd_clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (fifo_rd_en[i]) begin
        checkOutput($sformatf("read_of_empty_fifo_ch%0d", i), (fifoQ[i].size() == 0) ? 1 : 0, 0);
        if (fifoQ[i].size() != 0) rdData[i] <= fifoQ[i].pop_front();
      end
      fifoEmptyR[i] <= (fifoQ[i].size() == 0);
    end
  end

  assign fifo_empty = fifoEmptyR;

  always_comb begin
    fifo_rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) fifo_rd_data[i*DW +: DW] = rdData[i];
  end

  // Monitor: read-port rules, credit bound and scoreboard pops, sampled mid-cycle.
  always @(negedge rd_clk) begin
    int rdCh;
    int issued;
    int popped;
    logic [DW-1:0] expWord;
    if (!rd_rst_n) begin
      outstanding = 0;
    end else begin
      cycleCnt++;
      rdCh   = -1;
      issued = (fifo_rd_en != '0) ? 1 : 0;
      popped = (out_valid && out_ready) ? 1 : 0;
      if (issued != 0) begin
        checkOutput("rd_en_onehot", $countones(fifo_rd_en), 1);
        for (int i = 0; i < NUM_CH; i++) begin
          if (fifo_rd_en[i]) begin
            checkOutput($sformatf("rd_en_flag_empty_ch%0d", i), int'(fifo_empty[i]), 0);
            rdCount[i]++;
            rdCh = i;
          end
        end
        if (firstRdCycle < 0) firstRdCycle = cycleCnt;
      end
      if (logging && ((issued != 0) || (readLog.size() > 0))) readLog.push_back(rdCh);
      if (out_valid && (firstOutCycle < 0)) firstOutCycle = cycleCnt;
      if (popped != 0) begin
        popCount++;
        if ((int'(out_ch) >= NUM_CH) || (expQ[out_ch].size() == 0)) begin
          checkOutput($sformatf("unexpected_word_ch%0d", out_ch), int'(out_data), -1);
        end else begin
          expWord = expQ[out_ch].pop_front();
          checkOutput($sformatf("data_ch%0d", out_ch), int'(out_data), int'(expWord));
        end
      end
      outstanding = outstanding + issued - popped;
      if (issued != 0) checkOutput("credit_outstanding_le2", (outstanding <= 2) ? 1 : 0, 1);
    end
  end

  task automatic stepCycle();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic pushWord(input int ch, input logic [DW-1:0] d);
    fifoQ[ch].push_back(d);
    expQ[ch].push_back(d);
    pushCount++;
  endtask

  task automatic flushAll();
    for (int i = 0; i < NUM_CH; i++) begin
      fifoQ[i].delete();
      expQ[i].delete();
      rdCount[i] = 0;
    end
    readLog.delete();
    logging       = 1'b0;
    firstRdCycle  = -1;
    firstOutCycle = -1;
    popCount      = 0;
    pushCount     = 0;
  endtask

  task automatic doReset();
    stepCycle();
    rd_rst_n = 1'b0;
    flushAll();
    stepCycle();
    stepCycle();
    rd_rst_n = 1'b1;
  endtask

  function automatic bit sbEmpty();
    for (int i = 0; i < NUM_CH; i++) begin
      if ((expQ[i].size() != 0) || (fifoQ[i].size() != 0)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic waitDrained(input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      stepCycle();
      if (sbEmpty() && !busy && (outstanding == 0)) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput(name, int'(done), 1);
  endtask

  task automatic applyStimulus();
    out_ready = ($urandom_range(0, 99) < 60);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (($urandom_range(0, 99) < 20) && (fifoQ[ch].size() < DEPTH)) pushWord(ch, DW'($urandom));
    end
    stepCycle();
  endtask

  // Compare the reads of the log (gap cycles removed) against an expected channel sequence.
  task automatic checkReadOrder(input string name, input int expSeq [$]);
    int reads [$];
    int bad;
    foreach (readLog[k]) if (readLog[k] >= 0) reads.push_back(readLog[k]);
    checkOutput({name, "_count"}, reads.size(), expSeq.size());
    bad = 0;
    foreach (expSeq[k]) begin
      if ((k >= reads.size()) || (reads[k] != expSeq[k])) bad++;
    end
    checkOutput({name, "_order_errors"}, bad, 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int expSeq [$];
    int base;
    int bad;
    int act;
    int tot;
    bit hit;

    rd_rst_n  = 1'b1;
    ch_en     = '0;
    out_ready = 1'b0;
    #1 rd_rst_n = 1'b0;
    #3;
    checkOutput("rst_fifo_rd_en", int'(fifo_rd_en), 0);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_data", int'(out_data), 0);
    checkOutput("rst_out_ch", int'(out_ch), 0);
    checkOutput("rst_busy", int'(busy), 0);
    stepCycle();
    rd_rst_n = 1'b1;

    // Test 1: channel 2 alone holds three words.
    doReset();
    ch_en     = '1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) pushWord(2, DW'(k + 1));
    waitDrained(100, "t1_drain");
    checkOutput("t1_reads_ch2", rdCount[2], 3);
    checkOutput("t1_reads_other", rdCount[0] + rdCount[1] + rdCount[3], 0);
    checkOutput("t1_rd_to_valid_latency", firstOutCycle - firstRdCycle, 2);
    checkOutput("t1_busy_low", int'(busy), 0);

    // Test 2: all channels full, sustained bursts with one arbitration gap.
    doReset();
    ch_en     = '1;
    out_ready = 1'b1;
    logging   = 1'b1;
    for (int ch = 0; ch < NUM_CH; ch++) for (int k = 0; k < DEPTH; k++) pushWord(ch, DW'($urandom));
    waitDrained(300, "t2_drain");
    logging = 1'b0;
    tot = 0;
    for (int ch = 0; ch < NUM_CH; ch++) tot += rdCount[ch];
    checkOutput("t2_total_reads", tot, NUM_CH * DEPTH);
    checkOutput("t2_log_long_enough", (readLog.size() >= 71) ? 1 : 0, 1);
    for (int b = 0; b < 8; b++) begin
      bad = 0;
      for (int p = 0; p < BURST + 1; p++) begin
        int k;
        int req;
        k = b * (BURST + 1) + p;
        if (k >= 71) break;
        req = (p < BURST) ? (b % NUM_CH) : -1;
        act = (k < readLog.size()) ? readLog[k] : -2;
        if (act != req) bad++;
      end
      checkOutput($sformatf("t2_burst%0d_slot_errors", b), bad, 0);
    end

    // Test 3: downstream stall mid-burst.
    doReset();
    ch_en     = '1;
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) pushWord(0, DW'($urandom));
    hit = 1'b0;
    for (int c = 0; c < 50; c++) begin
      stepCycle();
      if (rdCount[0] >= 3) begin
        hit = 1'b1;
        break;
      end
    end
    checkOutput("t3_burst_started", int'(hit), 1);
    out_ready = 1'b0;
    base = rdCount[0];
    repeat (20) stepCycle();
    checkOutput("t3_reads_during_stall_le2", ((rdCount[0] - base) <= 2) ? 1 : 0, 1);
    checkOutput("t3_rd_en_without_credit", int'(fifo_rd_en), 0);
    checkOutput("t3_valid_held", int'(out_valid), 1);
    out_ready = 1'b1;
    waitDrained(100, "t3_drain");
    checkOutput("t3_total_reads", rdCount[0], 12);

    // Test 4: channel 1 disabled when its 4th read would issue.
    doReset();
    ch_en     = 4'b1110;
    out_ready = 1'b1;
    logging   = 1'b1;
    for (int k = 0; k < 8; k++) pushWord(1, DW'($urandom));
    for (int k = 0; k < 4; k++) pushWord(2, DW'($urandom));
    for (int k = 0; k < 2; k++) pushWord(3, DW'($urandom));
    hit = 1'b0;
    for (int c = 0; c < 50; c++) begin
      stepCycle();
      if (rdCount[1] >= 3) begin
        hit = 1'b1;
        break;
      end
    end
    ch_en[1] = 1'b0;
    checkOutput("t4_third_read_seen", int'(hit), 1);
    repeat (30) stepCycle();
    checkOutput("t4_ch1_reads", rdCount[1], 3);
    checkOutput("t4_ch1_undelivered", expQ[1].size(), 5);
    checkOutput("t4_ch2_delivered", expQ[2].size(), 0);
    checkOutput("t4_ch3_delivered", expQ[3].size(), 0);
    expSeq = '{1, 1, 1, 2, 2, 2, 2, 3, 3};
    checkReadOrder("t4", expSeq);

    // Test 5: asynchronous reset while a word is presented.
    doReset();
    ch_en     = '1;
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) pushWord(1, DW'($urandom));
    for (int c = 0; c < 30; c++) begin
      stepCycle();
      if (out_valid) break;
    end
    checkOutput("t5_valid_before_reset", int'(out_valid), 1);
    checkOutput("t5_ch_before_reset", int'(out_ch), 1);
    #3;
    rd_rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_fifo_rd_en", int'(fifo_rd_en), 0);
    checkOutput("t5_rst_out_valid", int'(out_valid), 0);
    checkOutput("t5_rst_out_data", int'(out_data), 0);
    checkOutput("t5_rst_out_ch", int'(out_ch), 0);
    checkOutput("t5_rst_busy", int'(busy), 0);
    stepCycle();
    flushAll();
    stepCycle();
    rd_rst_n  = 1'b1;
    out_ready = 1'b1;
    logging   = 1'b1;
    for (int ch = 0; ch < NUM_CH; ch++) for (int k = 0; k < 2; k++) pushWord(ch, DW'($urandom));
    waitDrained(100, "t5_drain");
    expSeq = '{0, 0, 1, 1, 2, 2, 3, 3};
    checkReadOrder("t5", expSeq);

    // Test 6: random fill against random backpressure.
    doReset();
    ch_en = '1;
    for (int c = 0; c < 10000; c++) applyStimulus();
    out_ready = 1'b1;
    waitDrained(2000, "t6_drain");
    checkOutput("t6_words_delivered", popCount, pushCount);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
